// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with configurable width, parity and stop bits,
// presenting frames through a valid/ready holding register with parity/framing/overrun flags.
module uart_rx_frame #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  baud_tick,
   input  logic                  rxd,
   input  logic [1:0]            parity_mode,
   input  logic                  two_stop,
   input  logic                  rx_ready,
   input  logic                  clr_overrun,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  PARITYERR,
   output logic                  FRAMEERR,
   output logic                  OVERRUNERR,
   output logic                  busy
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_t;

   state_t                r_state, w_next;
   logic                  r_sync1, r_sync2;
   logic [CW-1:0]         r_cnt;
   logic [BW-1:0]         r_bitn;
   logic [DATA_WIDTH-1:0] r_shift, r_rx_data;
   logic [1:0]            r_mode;
   logic                  r_two, r_perr, r_ferr;
   logic                  r_rx_valid, r_perr_o, r_ferr_o, r_ovr;
   logic                  w_smp, w_done, w_load, w_perr;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (baud_tick && !r_sync2) w_next = START;
         START:     if (w_smp) w_next = r_sync2 ? IDLE : DATA;
         DATA:      if (w_smp && r_bitn == BW'(DATA_WIDTH - 1)) w_next = (r_mode != 2'b00) ? PARITY : STOP1;
         PARITY:    if (w_smp) w_next = STOP1;
         STOP1:     if (w_smp) w_next = r_two ? STOP2 : (r_sync2 ? IDLE : WAIT_HIGH);
         STOP2:     if (w_smp) w_next = r_sync2 ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (r_sync2) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // The start bit is sampled half a bit in; every later sample lands on a bit centre.
   always_comb begin
      w_smp  = baud_tick && ((r_state == START) ? (r_cnt == CW'(OVERSAMPLE / 2 - 1))
                                                : (r_cnt == CW'(OVERSAMPLE - 1)));
      w_done = w_smp && (r_state == STOP2 || (r_state == STOP1 && !r_two));
      w_load = w_done && (!r_rx_valid || rx_ready);
      w_perr = (r_mode == 2'b01) ? (r_sync2 != ^r_shift) :
               (r_mode == 2'b10) ? (r_sync2 != ~^r_shift) :
               (r_mode == 2'b11) ? !r_sync2 : 1'b0;
      busy   = r_state != IDLE;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_cnt      <= '0;
         r_bitn     <= '0;
         r_shift    <= '0;
         r_mode     <= 2'b00;
         r_two      <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_perr_o   <= 1'b0;
         r_ferr_o   <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         if (r_state == IDLE) begin
            r_cnt  <= '0;
            r_bitn <= '0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            if (baud_tick && !r_sync2) begin
               r_mode <= parity_mode;
               r_two  <= two_stop;
            end
         end else if (baud_tick) begin
            r_cnt <= w_smp ? '0 : r_cnt + 1'b1;
            if (w_smp && r_state == DATA) begin
               r_shift <= {r_sync2, r_shift[DATA_WIDTH-1:1]};
               r_bitn  <= r_bitn + 1'b1;
            end
            if (w_smp && r_state == PARITY) r_perr <= w_perr;
            if (w_smp && (r_state == STOP1 || r_state == STOP2) && !r_sync2) r_ferr <= 1'b1;
         end
         if (w_load) begin
            r_rx_data  <= r_shift;
            r_perr_o   <= r_perr;
            r_ferr_o   <= r_ferr | !r_sync2;
            r_rx_valid <= 1'b1;
         end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (w_done && !w_load) r_ovr <= 1'b1;
         else if (clr_overrun)  r_ovr <= 1'b0;
      end
   end

   assign rx_data    = r_rx_data;
   assign rx_valid   = r_rx_valid;
   assign PARITYERR  = r_perr_o;
   assign FRAMEERR   = r_ferr_o;
   assign OVERRUNERR = r_ovr;
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive framer for the AHB UART, generalising the fixed 8-bit parity check into a full serial receiver. It oversamples the serial input, frames data of configurable width with none/even/odd/mark parity and 1 or 2 stop bits, and flags parity, framing and overrun errors. It presents received words to the AHB register block through a valid/ready holding register.

## Interface
- DATA_WIDTH, 8, data bits per frame (legal 5..9), LSB received first
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)
- HCLK  in  1  system clock; all state on rising edge
- HRESETn  in  1  asynchronous, active-low reset
- baud_tick  in  1  one-HCLK pulse, OVERSAMPLE per bit period
- rxd  in  1  asynchronous serial input, idle high
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit must be 1)
- two_stop  in  1  1 = two stop bits checked
- rx_ready  in  1  consumer accepts rx_data
- clr_overrun  in  1  one-cycle pulse, clears OVERRUNERR
- rx_data  out  DATA_WIDTH  received word
- rx_valid  out  1  rx_data/flags hold an unconsumed frame
- PARITYERR  out  1  parity error of the frame in rx_data
- FRAMEERR  out  1  stop bit(s) of the frame in rx_data sampled low
- OVERRUNERR  out  1  sticky: a completed frame was dropped
- busy  out  1  high in every state except IDLE

## Operation
- rxd passes through 2-flop synchroniser (both reset to 1) to give rxd_s; all decisions use rxd_s.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH. tick counter cnt and bit counter bitn.
- IDLE: on baud_tick with rxd_s==0 -> START, cnt=0; latch parity_mode and two_stop (mid-frame config changes ignored).
- START: cnt increments per baud_tick; at cnt==OVERSAMPLE/2-1 sample: 1 -> IDLE (glitch, no flags, nothing delivered); 0 -> DATA, cnt=0, bitn=0.
- DATA: sample at cnt==OVERSAMPLE-1 (bit centre), cnt wraps to 0; shift right, sample into MSB; after DATA_WIDTH samples -> PARITY if latched mode!=00, else STOP1.
- PARITY: sample p. Error when: even: p != ^data; odd: p != ~^data; mark: p != 1.
- STOP1: sample; 0 sets frame_err. If two_stop -> STOP2 else complete. STOP2: sample; 0 sets frame_err; complete.
- Complete: deliver frame (see below); next state IDLE if last stop sample was 1, WAIT_HIGH if 0 (break/framing). WAIT_HIGH -> IDLE on first rxd_s==1.
- Delivery: if rx_valid==0, or rx_valid && rx_ready same cycle: load rx_data, PARITYERR, FRAMEERR; rx_valid=1. Otherwise frame dropped, rx_data/flags retained, OVERRUNERR=1.
- rx_valid && rx_ready with no delivery that cycle: rx_valid=0; rx_data and flags hold last values.
- OVERRUNERR clears on clr_overrun; set wins if both in same cycle.

## Timing
- Reset: state IDLE, rx_data=0, rx_valid=0, PARITYERR=0, FRAMEERR=0, OVERRUNERR=0, busy=0, counters 0.
- HRESETn low mid-frame aborts immediately; partial frame never delivered.
- rxd to rxd_s: 2 HCLK. Start sample at OVERSAMPLE/2 ticks after falling edge detect; subsequent samples every OVERSAMPLE ticks.
- rx_valid, rx_data, error flags update on the HCLK edge after the baud_tick carrying the final stop sample (1-cycle latency).
- rx_valid falls the edge after handshake cycle; back-to-back frames need no idle gap beyond the stop bit(s).
- busy rises the edge after the START transition; low in IDLE only.

## Test plan
- 8N1 frame 0xA5 (start 0, 10100101 LSB first, stop 1), rx_ready=1 -> rx_data=0xA5, rx_valid 1 cycle, all flags 0.
- Even parity, 0xA5 with parity bit 1 -> PARITYERR=1; repeat with bit 0 -> PARITYERR=0; odd mode bit 1 -> 0; mark mode bit 0 -> 1.
- two_stop=1, second stop sampled 0 -> FRAMEERR=1, state WAIT_HIGH until rxd high; next clean frame 0x3C received with FRAMEERR=0.
- rx_ready=0, two frames 0x11 then 0x22 -> rx_data=0x11, OVERRUNERR=1; clr_overrun pulse -> 0; handshake on completion cycle of 0x22 -> rx_data=0x22, no overrun.
- rxd low pulse of OVERSAMPLE/4 ticks -> returns IDLE, rx_valid stays 0; DATA_WIDTH=5 frame 0x15 -> rx_data=5'h15.
- HRESETn asserted during DATA bit 3 -> all outputs at reset values; subsequent frame 0x5A received correctly.
